// File: rtl/lap_stopwatch_ctrl_pkg.sv
// Shared types, constants and time arithmetic for the lap stopwatch core.
package lap_stopwatch_ctrl_pkg;

    localparam int unsigned FIELD_W = 8;
    localparam logic [FIELD_W-1:0] CSEC_MAX = 8'd99;
    localparam logic [FIELD_W-1:0] SEC_MAX  = 8'd59;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } sw_state_e;

    typedef struct packed {
        logic [FIELD_W-1:0] min;
        logic [FIELD_W-1:0] sec;
        logic [FIELD_W-1:0] csec;
    } sw_time_t;

    // True when the time reads 00:00.00.
    function automatic logic time_is_zero(input sw_time_t t);
        return (t.min == '0) && (t.sec == '0) && (t.csec == '0);
    endfunction

    // One centisecond forward; wraps to zero after max_min:59.99.
    function automatic sw_time_t time_tick_up(input sw_time_t t, input logic [FIELD_W-1:0] max_min);
        sw_time_t r;
        r = t;
        if (t.csec < CSEC_MAX) begin
            r.csec = t.csec + 8'd1;
        end else begin
            r.csec = '0;
            if (t.sec < SEC_MAX) begin
                r.sec = t.sec + 8'd1;
            end else begin
                r.sec = '0;
                r.min = (t.min < max_min) ? t.min + 8'd1 : '0;
            end
        end
        return r;
    endfunction

    // One centisecond backward with borrow; saturates at zero.
    function automatic sw_time_t time_tick_down(input sw_time_t t);
        sw_time_t r;
        r = t;
        if (time_is_zero(t)) begin
            r = '0;
        end else if (t.csec != '0) begin
            r.csec = t.csec - 8'd1;
        end else begin
            r.csec = CSEC_MAX;
            if (t.sec != '0) begin
                r.sec = t.sec - 8'd1;
            end else begin
                r.sec = SEC_MAX;
                r.min = t.min - 8'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/lap_stopwatch_ctrl_btn_rise_edge.sv
// Rising-edge detector for one debounced, synchronous button level.
module lap_stopwatch_ctrl_btn_rise_edge (
    input  logic clk,
    input  logic reset_p,
    input  logic btn,
    output logic rise_c
);

    logic btn_prev;

    // Previous level; cleared on reset so a button held through reset yields an edge.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            btn_prev <= 1'b0;
        end else begin
            btn_prev <= btn;
        end
    end

    assign rise_c = btn & ~btn_prev;

endmodule

// File: rtl/lap_stopwatch_ctrl.sv
// Stopwatch/timer core: up/down centisecond counter, lap ring buffer, display mux.
module lap_stopwatch_ctrl
    import lap_stopwatch_ctrl_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 1_000_000,
    parameter int unsigned MAX_MIN   = 99,
    parameter int unsigned LAP_DEPTH = 8,
    parameter int unsigned HOLD_CS   = 200
) (
    input  logic                           clk,
    input  logic                           reset_p,
    input  logic                           btn_start,
    input  logic                           btn_lap,
    input  logic                           btn_clear,
    input  logic                           btn_mode,
    input  logic [7:0]                     preset_min,
    input  logic [7:0]                     preset_sec,
    output logic [7:0]                     fnd_min,
    output logic [7:0]                     fnd_sec,
    output logic [7:0]                     fnd_csec,
    output logic                           running,
    output logic                           down_mode,
    output logic                           lap_view,
    output logic [$clog2(LAP_DEPTH)-1:0]   lap_idx,
    output logic [$clog2(LAP_DEPTH):0]     lap_count,
    output logic                           alarm
);

    localparam int unsigned IDX_W  = $clog2(LAP_DEPTH);
    localparam int unsigned CNT_W  = IDX_W + 1;
    localparam int unsigned DIV_W  = $clog2(TICK_DIV);
    localparam int unsigned HOLD_W = (HOLD_CS < 1) ? 1 : $clog2(HOLD_CS + 1);
    localparam logic [FIELD_W-1:0] MAX_MIN_F = FIELD_W'(MAX_MIN);

    logic start_rise_c, lap_rise_c, clear_rise_c, mode_rise_c;
    logic clr_e_c, start_e_c, mode_e_c, lap_e_c;

    sw_state_e          state_q, state_d;
    sw_time_t           time_q, time_d, preset_time_c, disp_c;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [IDX_W-1:0]   wr_ptr_q, wr_ptr_d, rd_addr_c;
    logic [IDX_W-1:0]   lap_idx_d;
    logic [CNT_W-1:0]   lap_count_d;
    logic               lap_view_d, down_d, alarm_d, buf_we, tick;
    sw_time_t           lap_buf [LAP_DEPTH];

    lap_stopwatch_ctrl_btn_rise_edge u_btn_start (.clk(clk), .reset_p(reset_p), .btn(btn_start), .rise_c(start_rise_c));
    lap_stopwatch_ctrl_btn_rise_edge u_btn_lap   (.clk(clk), .reset_p(reset_p), .btn(btn_lap),   .rise_c(lap_rise_c));
    lap_stopwatch_ctrl_btn_rise_edge u_btn_clear (.clk(clk), .reset_p(reset_p), .btn(btn_clear), .rise_c(clear_rise_c));
    lap_stopwatch_ctrl_btn_rise_edge u_btn_mode  (.clk(clk), .reset_p(reset_p), .btn(btn_mode),  .rise_c(mode_rise_c));

    // Button priority: clear > start > mode > lap; losers are dropped.
    assign clr_e_c   = clear_rise_c;
    assign start_e_c = start_rise_c & ~clr_e_c;
    assign mode_e_c  = mode_rise_c  & ~clr_e_c & ~start_rise_c;
    assign lap_e_c   = lap_rise_c   & ~clr_e_c & ~start_rise_c & ~mode_rise_c;

    assign preset_time_c = '{min: preset_min, sec: preset_sec, csec: 8'd0};
    assign rd_addr_c     = wr_ptr_q - IDX_W'(1) - lap_idx;
    assign disp_c        = lap_view ? lap_buf[rd_addr_c] : time_q;

    // Next-state, timekeeping and lap bookkeeping.
    always_comb begin
        state_d     = state_q;
        time_d      = time_q;
        div_d       = div_q;
        hold_d      = hold_q;
        wr_ptr_d    = wr_ptr_q;
        lap_idx_d   = lap_idx;
        lap_count_d = lap_count;
        lap_view_d  = lap_view;
        down_d      = down_mode;
        alarm_d     = 1'b0;
        buf_we      = 1'b0;
        tick        = (state_q == ST_RUN) && (div_q == DIV_W'(TICK_DIV - 1));

        if (state_q == ST_RUN) begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
        end

        if (clr_e_c) begin
            state_d     = ST_IDLE;
            time_d      = down_mode ? preset_time_c : '0;
            div_d       = '0;
            hold_d      = '0;
            wr_ptr_d    = '0;
            lap_idx_d   = '0;
            lap_count_d = '0;
            lap_view_d  = 1'b0;
        end else begin
            if (tick) begin
                if (down_mode) begin
                    time_d = time_tick_down(time_q);
                    if (time_is_zero(time_d)) begin
                        state_d = ST_DONE;
                        alarm_d = 1'b1;
                    end
                end else begin
                    time_d = time_tick_up(time_q, MAX_MIN_F);
                end
                if (hold_q != '0) begin
                    hold_d = hold_q - HOLD_W'(1);
                    if (hold_q == HOLD_W'(1)) begin
                        lap_view_d = 1'b0;
                    end
                end
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_e_c) begin
                        if (!(down_mode && time_is_zero(time_q))) begin
                            state_d = ST_RUN;
                        end
                    end else if (mode_e_c) begin
                        down_d = ~down_mode;
                        time_d = down_mode ? '0 : preset_time_c;
                    end
                end
                ST_RUN: begin
                    if (start_e_c) begin
                        if (state_d == ST_RUN) begin
                            state_d = ST_PAUSE;
                        end
                    end else if (lap_e_c) begin
                        buf_we     = 1'b1;
                        wr_ptr_d   = wr_ptr_q + IDX_W'(1);
                        lap_view_d = 1'b1;
                        lap_idx_d  = '0;
                        hold_d     = HOLD_W'(HOLD_CS);
                        if (lap_count != CNT_W'(LAP_DEPTH)) begin
                            lap_count_d = lap_count + CNT_W'(1);
                        end
                    end
                end
                ST_PAUSE: begin
                    if (start_e_c) begin
                        state_d    = ST_RUN;
                        lap_view_d = 1'b0;
                        lap_idx_d  = '0;
                        hold_d     = '0;
                    end else if (lap_e_c && (lap_count != '0)) begin
                        if (!lap_view) begin
                            lap_view_d = 1'b1;
                            lap_idx_d  = '0;
                        end else if (CNT_W'(lap_idx) == lap_count - CNT_W'(1)) begin
                            lap_view_d = 1'b0;
                            lap_idx_d  = '0;
                        end else begin
                            lap_idx_d = lap_idx + IDX_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State register with registered status flags.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            state_q   <= ST_IDLE;
            running   <= 1'b0;
            down_mode <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            state_q   <= state_d;
            running   <= (state_d == ST_RUN);
            down_mode <= down_d;
            alarm     <= alarm_d;
        end
    end

    // Time, divider, hold counter and lap pointers.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            time_q    <= '0;
            div_q     <= '0;
            hold_q    <= '0;
            wr_ptr_q  <= '0;
            lap_idx   <= '0;
            lap_count <= '0;
            lap_view  <= 1'b0;
        end else begin
            time_q    <= time_d;
            div_q     <= div_d;
            hold_q    <= hold_d;
            wr_ptr_q  <= wr_ptr_d;
            lap_idx   <= lap_idx_d;
            lap_count <= lap_count_d;
            lap_view  <= lap_view_d;
        end
    end

    // Lap ring buffer; stores the time as it stood before this cycle's tick.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            for (int i = 0; i < int'(LAP_DEPTH); i++) begin
                lap_buf[i] <= '0;
            end
        end else if (buf_we) begin
            lap_buf[wr_ptr_q] <= time_q;
        end
    end

    // Registered display mux: stored lap or live time.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            fnd_min  <= '0;
            fnd_sec  <= '0;
            fnd_csec <= '0;
        end else begin
            fnd_min  <= disp_c.min;
            fnd_sec  <= disp_c.sec;
            fnd_csec <= disp_c.csec;
        end
    end

endmodule
